mico8_fetch: RTL
================

# mico8_fetch

Instruction-fetch stage of the Mico8 core, sitting directly upstream of the 512×18 program pROM (bypass read mode, one-cycle read latency). Owns the program counter and the hardware call/return stack, drives the pROM address/enable pins, and presents each 18-bit instruction with its PC and a valid flag to the decode/execute stage. Jumps, calls and returns from execute redirect fetch with zero bubbles by steering the pROM address combinationally.

## Interface
- PC_W, 9, program address width (pROM depth 2^PC_W)
- INSN_W, 18, instruction width
- STACK_DEPTH, 16, call-stack entries (power of two, ≥2)

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  execute not ready; freeze fetch
- redirect_valid  in  1  execute requests control transfer for the instruction currently presented
- redirect_kind  in  2  00 jump, 01 call, 10 return, 11 reserved (treated as jump)
- redirect_target  in  PC_W  destination for jump/call (ignored for return)
- rom_ad  out  PC_W  pROM address
- rom_ce  out  1  pROM clock enable
- rom_oce  out  1  pROM output enable (equals rom_ce)
- rom_reset  out  1  pROM sync reset, tied 0
- rom_dout  in  INSN_W  pROM data
- insn  out  INSN_W  instruction to decode (= rom_dout)
- insn_pc  out  PC_W  address of insn
- insn_valid  out  1  insn/insn_pc meaningful
- stack_overflow  out  1  sticky: call with full stack
- stack_underflow  out  1  sticky: return with empty stack

## Operation
- State: fetch_pc (next sequential address), pc_q (address of in-flight/presented word), valid_q, stack array, sp (0..STACK_DEPTH), two sticky flags.
- accept = insn_valid & redirect_valid & ~stall; redirects while stalled or while insn_valid=0 are ignored (execute holds them).
- next_addr (combinational): accept & kind==10 → stack[sp-1] (0 if sp==0); accept & other kind → redirect_target; else fetch_pc.
- rom_ad = next_addr; rom_ce = rom_oce = ~stall.
- Each edge with ~stall: pc_q ← next_addr; fetch_pc ← next_addr+1 mod 2^PC_W; valid_q ← 1.
- Stall: fetch_pc, pc_q, valid_q, stack frozen; rom_ce=0 so pROM holds dout, insn stable.
- Call (accepted): push insn_pc+1 mod 2^PC_W, sp+1. If sp==STACK_DEPTH: no write, sp unchanged, stack_overflow←1; redirect still taken.
- Return (accepted): pop, sp−1. If sp==0: target 0, sp stays 0, stack_underflow←1.
- Sticky flags cleared only by reset.
- insn = rom_dout, insn_pc = pc_q, insn_valid = valid_q.

## Timing
- Reset (async assert): fetch_pc=0, pc_q=0, valid_q=0, sp=0, flags 0; insn_valid=0, insn_pc=0, rom_ad=0, rom_ce=~stall, rom_reset=0; insn follows rom_dout (don't-care while invalid).
- First rising edge after reset_n release with stall=0 latches address 0; insn_valid=1, insn_pc=0 in the following cycle.
- Fetch latency: address on rom_ad at edge N → insn at cycle N+1; throughput one instruction/cycle.
- Redirect penalty: zero cycles; target instruction presented the cycle after accept.
- Reset mid-stall or mid-redirect: all state to reset values immediately; stack contents need not be cleared (sp=0 suffices).
- fetch_pc wrap: 2^PC_W−1 → 0, no flag.

## Test plan
- Reset release, stall=0, pROM word k = 0x00100+k: insn_pc 0,1,2,3 on consecutive cycles, insn_valid high from cycle 1, insn=0x00100..0x00103.
- Stall for 3 cycles while insn_pc=5: insn_pc=5, insn, insn_valid unchanged, rom_ce=0; after release insn_pc=6 next cycle.
- Jump at insn_pc=4 to 0x1F0: next cycle insn_pc=0x1F0, no bubble; stalled redirect ignored until stall drops.
- Call at pc 10 to 0x80, return at 0x82: insn_pc sequence 10,0x80,0x81,0x82,11; sp 0→1→0.
- 17 nested calls with STACK_DEPTH=16: stack_overflow=1 after 17th, sp=16; 17 returns: 16 correct addresses, then target 0 and stack_underflow=1; both stay set until reset_n low.
- Sequential fetch from 0x1FE: insn_pc 0x1FE,0x1FF,0x000; call at 0x1FF pushes 0x000.

Source files
------------

// File: rtl/mico8_fetch.sv
// Mico8 instruction fetch: program counter, call/return stack and pROM address steering.
// Redirects steer rom_ad combinationally so a taken jump/call/return costs no bubble.
module mico8_fetch #(
  parameter int PC_W        = 9,
  parameter int INSN_W      = 18,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [PC_W-1:0]   redirect_target,
  output logic [PC_W-1:0]   rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [INSN_W-1:0] rom_dout,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc,
  output logic              insn_valid,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  localparam logic [1:0] KIND_CALL = 2'b01;
  localparam logic [1:0] KIND_RET  = 2'b10;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  pc_q;
  logic             valid_q;
  logic [SP_W-1:0]  sp;
  logic             ovf_q;
  logic             unf_q;
  logic [PC_W-1:0]  stack [STACK_DEPTH];

  logic             accept;
  logic             is_call;
  logic             is_ret;
  logic             stack_full;
  logic             stack_empty;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic [PC_W-1:0]  ret_addr;
  logic [PC_W-1:0]  next_addr;
  logic [PC_W-1:0]  link_addr;

  assign accept      = valid_q & redirect_valid & ~stall;
  assign is_ret      = (redirect_kind == KIND_RET);
  assign is_call     = (redirect_kind == KIND_CALL);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign push_idx    = IDX_W'(sp);
  assign link_addr   = pc_q + PC_W'(1);

  // Return to an empty stack lands on address 0 rather than a stale entry.
  assign ret_addr = stack_empty ? '0 : stack[top_idx];

  always_comb begin
    next_addr = fetch_pc;
    if (accept) begin
      if (is_ret) next_addr = ret_addr;
      else        next_addr = redirect_target;
    end
  end

  assign rom_ad    = next_addr;
  assign rom_ce    = ~stall;
  assign rom_oce   = ~stall;
  assign rom_reset = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
    end else if (!stall) begin
      pc_q     <= next_addr;
      fetch_pc <= next_addr + PC_W'(1);
      valid_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (accept) begin
      if (is_call) begin
        if (stack_full) ovf_q <= 1'b1;
        else            sp    <= sp + SP_W'(1);
      end else if (is_ret) begin
        if (stack_empty) unf_q <= 1'b1;
        else             sp    <= sp - SP_W'(1);
      end
    end
  end

  // Entries need no reset: sp alone decides which ones are live.
  always_ff @(posedge clk) begin
    if (accept && is_call && !stack_full)
      stack[push_idx] <= link_addr;
  end

  assign insn            = rom_dout;
  assign insn_pc         = pc_q;
  assign insn_valid      = valid_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule
